// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal segments,
// one per register stage, with a valid/ready handshake and carry/overflow/zero flags.
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;
  // Interior register count; STAGES=1 keeps a single unused slot so the arrays stay legal.
  localparam int NR  = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  function automatic logic ovf_flag(input logic a_msb, input logic bp_msb, input logic res_msb);
    return (a_msb == bp_msb) && (res_msb != a_msb);
  endfunction

  logic en;

  logic [WIDTH-1:0] a_p   [NR];
  logic [WIDTH-1:0] bp_p  [NR];
  logic [WIDTH-1:0] res_p [NR];
  logic             c_p   [NR];
  logic             vld_p [NR];

  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_bp  [STAGES];
  logic [WIDTH-1:0] src_res [STAGES];
  logic             src_c   [STAGES];
  logic             src_vld [STAGES];

  // A stalled output freezes the whole pipe; bubbles are not squeezed out.
  assign in_ready = !out_valid || out_ready;
  assign en       = in_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] res_nxt;

    if (s == 0) begin : g_src_in
      // Subtraction is A + ~B + 1: invert B here and inject the +1 as carry-in.
      assign src_a[s]   = a;
      assign src_bp[s]  = op ? ~b : b;
      assign src_res[s] = '0;
      assign src_c[s]   = op;
      assign src_vld[s] = in_valid;
    end else begin : g_src_reg
      assign src_a[s]   = a_p[s-1];
      assign src_bp[s]  = bp_p[s-1];
      assign src_res[s] = res_p[s-1];
      assign src_c[s]   = c_p[s-1];
      assign src_vld[s] = vld_p[s-1];
    end

    assign seg_sum = {1'b0, src_a[s][s*SEG +: SEG]}
                   + {1'b0, src_bp[s][s*SEG +: SEG]}
                   + {{SEG{1'b0}}, src_c[s]};

    always_comb begin
      res_nxt                = src_res[s];
      res_nxt[s*SEG +: SEG]  = seg_sum[SEG-1:0];
    end

    if (s < STAGES - 1) begin : g_mid
      // ---- stage boundary: segment s summed, carry handed to stage s+1 ----
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     vld_p[s] <= 1'b0;
        else if (en) vld_p[s] <= src_vld[s];
      end

      always_ff @(posedge clk) begin
        if (en) begin
          a_p[s]   <= src_a[s];
          bp_p[s]  <= src_bp[s];
          res_p[s] <= res_nxt;
          c_p[s]   <= seg_sum[SEG];
        end
      end
    end else begin : g_last
      // ---- stage boundary: final segment summed, result and flags registered ----
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          out       <= '0;
          carry     <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (en) begin
          out_valid <= src_vld[s];
          out       <= res_nxt;
          carry     <= seg_sum[SEG];
          ovf       <= ovf_flag(src_a[s][WIDTH-1], src_bp[s][WIDTH-1], res_nxt[WIDTH-1]);
          zero      <= ~|res_nxt;
        end
      end
    end
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the 64-bit combinational adder: adds or subtracts two WIDTH-bit operands.
- The carry chain is split into STAGES equal segments, one segment per pipeline stage, so wide adds close timing.
- Valid/ready handshakes on input and output; produces carry, signed-overflow and zero flags.
- Sits between operand-producing logic and any result consumer in the lab datapath.

Parameters:
WIDTH, 64, operand/result width in bits; WIDTH % STAGES must be 0 (elaboration error otherwise).
STAGES, 4, number of pipeline stages; 1 to WIDTH; SEG = WIDTH/STAGES bits per stage.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand set present.
in_ready  out  1  block can accept this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
op  in  1  0 = A+B, 1 = A-B.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts result.
out  out  WIDTH  result.
carry  out  1  final carry-out. For subtract: 1 = no borrow.
ovf  out  1  signed (two's-complement) overflow.
zero  out  1  out == 0.

Behaviour:
- Reset (async, any time): all stage valid bits and out_valid go to 0 immediately; out, carry, ovf and zero go to 0. In-flight operations are discarded and never emerge. First acceptance is possible on the first edge after rst deasserts.
- in_ready = !out_valid || out_ready. This is a global enable: when it is 0, every stage register (data and valid) holds, and interior bubbles are not collapsed.
- Accept: on an edge with in_valid && in_ready.
  - Latch a, b' = op ? ~b : b, and cin = op.
  - Stage 1 computes segment 0 (bits SEG-1:0) plus cin.
- Stage k (k = 2..STAGES):
  - Adds segment k-1 of a and b' plus the registered carry from stage k-1.
  - Upper, not-yet-summed segments travel forward unchanged.
  - Lower, already-computed sum segments travel forward unchanged.
- Latency: an operation accepted at edge n has out_valid = 1 and valid out/flags after edge n+STAGES-1, assuming no stall. STAGES=1 therefore gives a single registered result.
- Throughput: one operation per cycle while out_ready = 1.
- Output handshake: out, carry, ovf and zero hold stable while out_valid && !out_ready. The result is consumed on an edge with out_valid && out_ready.
- Simultaneous consume and accept on the same edge is allowed; a full pipeline advances by one with no loss.
- Flags, computed on the final stage and registered with out:
  - carry = carry-out of the MSB segment.
  - ovf = (a[W-1] == b'[W-1]) && (out[W-1] != a[W-1]).
  - zero = ~|out.
- Ordering: results leave in acceptance order. No drop or duplication under any in_valid/out_ready pattern.
- Operands and op are don't-care when in_valid = 0. Bubbles propagate as valid = 0.

Test Plan (WIDTH=64, STAGES=4 unless stated):
1. a=64'h1, b=64'h2, op=0 at edge n -> after edge n+3: out_valid=1, out=64'h3, carry=0, ovf=0, zero=0.
2. a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1, op=0 -> out=64'h0, carry=1, zero=1, ovf=0 (carry ripples through all 4 stages).
3. a=64'h7FFF_FFFF_FFFF_FFFF, b=64'h1, op=0 -> out=64'h8000_0000_0000_0000, ovf=1, carry=0.
4. Subtract cases:
   - a=5, b=5, op=1 -> out=0, carry=1, zero=1.
   - a=0, b=1, op=1 -> out=64'hFFFF_FFFF_FFFF_FFFF, carry=0, ovf=0.
5. Backpressure:
   - Stimulus: 8 back-to-back ops (a=i, b=10*i, alternating op), with out_ready=0 for 3 cycles once the first result is out.
   - Required: in_ready=0 during the stall; out held stable; all 8 results emerge in order with correct values.
6. Reset and STAGES=1:
   - With 3 ops in flight, pulse rst mid-cycle -> out_valid=0 immediately and no stale result appears afterwards.
   - Rerun with STAGES=1 -> test 1 gives its result after edge n.
